shift_register_univ: RTL
========================

// Module: shift_register_univ
// PURPOSE
//  Parametrised universal shift register: parallel load, shift right, shift left, hold.
//  Counts shifts and pulses frame_done after every WIDTH shifts since the last load.
//  Serves as the team's parallel<->serial converter core (serializer and deserializer).
//  Optional rotate mode recirculates the shifted-out bit instead of taking serial input.
// PARAMETERS
//  WIDTH     8      data width in bits; legal range >= 2.
//  ROTATE    0      1: the shifted-out bit re-enters at the opposite end; sin_r and sin_l are ignored.
//  RST_VAL   '0     value of the register after reset (WIDTH bits).
//  CW        $clog2(WIDTH)   width of the shift counter (localparam, not overridable).
// PORTS
//  clk         in   1      clock; all state updates on its rising edge.
//  reset       in   1      asynchronous, active-high reset.
//  en          in   1      clock enable; 0 = hold everything (register, counter, flags).
//  mode        in   2      00 hold, 01 shift right, 10 shift left, 11 parallel load.
//  sin_r       in   1      serial input for shift right; enters at bit WIDTH-1.
//  sin_l       in   1      serial input for shift left; enters at bit 0.
//  din         in   WIDTH  parallel load data.
//  dout        out  WIDTH  current register contents.
//  sout_r      out  1      = dout[0]; the bit leaving on a right shift.
//  sout_l      out  1      = dout[WIDTH-1]; the bit leaving on a left shift.
//  shift_cnt   out  CW     number of shifts since the last load, modulo WIDTH.
//  frame_done  out  1      one-cycle pulse when the WIDTH-th shift since the last load/wrap completes.
// BEHAVIOUR
//  - Reset (async, any time, including mid-frame): dout=RST_VAL, shift_cnt=0, frame_done=0.
//    The first rising clk edge after reset deasserts behaves normally.
//  - All outputs are registered or direct decodes of registers; no combinational input->output path.
//  - When en=0: all state holds; frame_done is forced to 0 on the next edge (it never stretches).
//  - When en=1, at each rising edge:
//    mode 00 hold  : dout and shift_cnt unchanged; frame_done<=0.
//    mode 01 right : dout <= {in, dout[WIDTH-1:1]}; in = ROTATE ? dout[0] : sin_r.
//    mode 10 left  : dout <= {dout[WIDTH-2:0], in}; in = ROTATE ? dout[WIDTH-1] : sin_l.
//    mode 11 load  : dout <= din; shift_cnt <= 0; frame_done <= 0.
//  - Shift counter (modes 01/10 only): if shift_cnt==WIDTH-1 then shift_cnt<=0 and frame_done<=1,
//    else shift_cnt<=shift_cnt+1 and frame_done<=0.
//    Left and right shifts both count; mixing directions within a frame is legal.
//  - frame_done is high exactly in the cycle after the completing edge and is cleared by the next
//    edge unless that edge completes another frame (not possible for WIDTH>=2).
//  - Load during a partial frame discards the count (restart, no frame_done).
//  - Latency: a load or shift is visible on dout/sout_* one edge after sampling.
//  - Serializer use: load, then WIDTH right shifts; sout_r presents din[0] first, LSB-first.
//  - Deserializer use: WIDTH right shifts of sin_r; first bit received ends up in dout[0]
//    when frame_done is high.
// TESTING (WIDTH=8 unless noted)
//  1 reset high mid-stream with dout=8'hA5 -> dout=8'h00, shift_cnt=0, frame_done=0 immediately, clk-independent.
//  2 load din=8'hB4, then 8 right shifts, sin_r=0 -> sout_r sequence 0,0,1,0,1,1,0,1;
//    frame_done=1 only after the 8th edge; dout=8'h00.
//  3 8 right shifts, sin_r=1,0,1,1,0,0,1,0 -> dout=8'h4D with frame_done=1; shift_cnt=0.
//  4 ROTATE=1, load 8'h81, then 1 left shift -> 8'h03; then 2 right shifts -> 8'hC0;
//    sin_l and sin_r are toggled and ignored.
//  5 load, 5 shifts (shift_cnt=5), en=0 for 3 cycles (state holds), reload -> shift_cnt=0,
//    no frame_done pulse.
//  6 mode=00 for 10 edges with en=1 -> dout, shift_cnt unchanged, frame_done=0; repeat 2 with WIDTH=4, din=4'h9.

Source files
------------

// File: rtl/shift_register_univ.sv
// -----------------------------------------------------------------------------
// shift_register_univ
//   Universal shift register: parallel load, shift right, shift left, hold.
//   Counts shifts since the last load (modulo WIDTH). It pulses frame_done for
//   one cycle after every WIDTH-th shift. Used as the parallel<->serial core:
//   load + WIDTH right shifts serialises LSB-first on sout_r. WIDTH right
//   shifts of sin_r deserialise, with the first bit received landing in dout[0].
//   With ROTATE=1 the bit shifted out re-enters at the opposite end.
//
// Ports
//   clk         in   1      rising-edge clock
//   reset       in   1      asynchronous, active-high reset
//   en          in   1      clock enable (0 = hold state, frame_done drops)
//   mode        in   2      00 hold, 01 shift right, 10 shift left, 11 load
//   sin_r       in   1      serial in for right shift (enters at MSB)
//   sin_l       in   1      serial in for left shift (enters at LSB)
//   din         in   WIDTH  parallel load data
//   dout        out  WIDTH  register contents
//   sout_r      out  1      dout[0], bit leaving on a right shift
//   sout_l      out  1      dout[WIDTH-1], bit leaving on a left shift
//   shift_cnt   out  CW     shifts since last load, modulo WIDTH
//   frame_done  out  1      one-cycle pulse after the WIDTH-th shift
// -----------------------------------------------------------------------------
module shift_register_univ #(
    parameter int               WIDTH   = 8,
    parameter bit               ROTATE  = 1'b0,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    localparam int              CW      = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             sout_r,
    output logic             sout_l,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    localparam logic [1:0] MODE_HOLD  = 2'b00;
    localparam logic [1:0] MODE_RIGHT = 2'b01;
    localparam logic [1:0] MODE_LEFT  = 2'b10;
    localparam logic [1:0] MODE_LOAD  = 2'b11;

    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_data;
    logic [CW-1:0]    r_cnt;
    logic             r_done;

    logic             w_in_r;
    logic             w_in_l;
    logic             w_wrap;

    // In rotate mode the serial inputs are ignored entirely.
    assign w_in_r = ROTATE ? r_data[0]       : sin_r;
    assign w_in_l = ROTATE ? r_data[WIDTH-1] : sin_l;
    assign w_wrap = (r_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RST_VAL;
            r_cnt  <= '0;
            r_done <= 1'b0;
        end else if (!en) begin
            // Everything holds, but the pulse must not stretch.
            r_done <= 1'b0;
        end else begin
            case (mode)
                MODE_RIGHT, MODE_LEFT: begin
                    if (mode == MODE_RIGHT)
                        r_data <= {w_in_r, r_data[WIDTH-1:1]};
                    else
                        r_data <= {r_data[WIDTH-2:0], w_in_l};
                    // Both directions count toward the same frame.
                    if (w_wrap) begin
                        r_cnt  <= '0;
                        r_done <= 1'b1;
                    end else begin
                        r_cnt  <= r_cnt + CW'(1);
                        r_done <= 1'b0;
                    end
                end
                MODE_LOAD: begin
                    // A load mid-frame discards the partial count.
                    r_data <= din;
                    r_cnt  <= '0;
                    r_done <= 1'b0;
                end
                default: begin
                    r_done <= 1'b0;
                end
            endcase
        end
    end

    assign dout       = r_data;
    assign sout_r     = r_data[0];
    assign sout_l     = r_data[WIDTH-1];
    assign shift_cnt  = r_cnt;
    assign frame_done = r_done;

endmodule
